// File: rtl/sparc_window_regfile_pkg.sv
// Shared constants and logical-to-physical register mapping for the SPARC windowed register file.
package sparc_rf_pkg;

  localparam int unsigned NUM_GLOBALS  = 8;
  localparam int unsigned REGS_PER_WIN = 16;
  localparam int unsigned OUTS_BASE    = 8;
  localparam int unsigned LOCALS_BASE  = 16;
  localparam int unsigned INS_BASE     = 24;

  // Ins of window w are the outs of window (w+1) mod nwin; cwp is assumed < nwin.
  function automatic int unsigned phys_idx(input logic [4:0] lreg,
                                           input int unsigned cwp,
                                           input int unsigned nwin);
    int unsigned r;
    int unsigned win;
    int unsigned result;
    r = 32'(lreg);
    if (r < OUTS_BASE) begin
      result = r;
    end else if (r < INS_BASE) begin
      result = NUM_GLOBALS + REGS_PER_WIN * cwp + (r - OUTS_BASE);
    end else begin
      win    = (cwp + 32'd1 == nwin) ? 32'd0 : cwp + 32'd1;
      result = NUM_GLOBALS + REGS_PER_WIN * win + (r - INS_BASE);
    end
    return result;
  endfunction

endpackage

// File: rtl/sparc_window_regfile_if.sv
// Register-file access bundle between the integer-unit controller (master) and the register file (slave).
interface sparc_window_regfile_if #(
  parameter int DATA_W = 32,
  parameter int NWIN   = 8,
  parameter int CWP_W  = $clog2(NWIN)
);
  logic [4:0]        RdA_Addr;
  logic [4:0]        RdB_Addr;
  logic [DATA_W-1:0] PortA;
  logic [DATA_W-1:0] PortB;
  logic [4:0]        Wr_Addr;
  logic [DATA_W-1:0] Wr_Data;
  logic              Wr_En;
  logic              Save;
  logic              Restore;
  logic              Cwp_Ld;
  logic [CWP_W-1:0]  Cwp_In;
  logic [NWIN-1:0]   WIM;
  logic [CWP_W-1:0]  Cwp;
  logic              Wof_Trap;
  logic              Wuf_Trap;

  modport master (
    output RdA_Addr, RdB_Addr, Wr_Addr, Wr_Data, Wr_En,
    output Save, Restore, Cwp_Ld, Cwp_In, WIM,
    input  PortA, PortB, Cwp, Wof_Trap, Wuf_Trap
  );

  modport slave (
    input  RdA_Addr, RdB_Addr, Wr_Addr, Wr_Data, Wr_En,
    input  Save, Restore, Cwp_Ld, Cwp_In, WIM,
    output PortA, PortB, Cwp, Wof_Trap, Wuf_Trap
  );
endinterface

// File: rtl/sparc_window_regfile_addr_map.sv
// Combinational translation of a logical register number plus CWP into a physical register index.
module rf_addr_map
  import sparc_rf_pkg::*;
#(
  parameter int NWIN   = 8,
  parameter int CWP_W  = $clog2(NWIN),
  parameter int PHYS_W = $clog2(8 + 16 * NWIN)
) (
  input  logic [4:0]        lreg,
  input  logic [CWP_W-1:0]  cwp,
  output logic [PHYS_W-1:0] phys
);

  assign phys = PHYS_W'(phys_idx(lreg, 32'(cwp), 32'(NWIN)));

endmodule

// File: rtl/sparc_window_regfile.sv
// Parametrised SPARC windowed register file with internal CWP, SAVE/RESTORE and WIM trap detection.
// Optional macro RF_BYPASS_EN forwards same-cycle write data to matching read ports.
module sparc_window_regfile
  import sparc_rf_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NWIN   = 8,
  parameter int CWP_W  = $clog2(NWIN)
) (
  input logic                    Clk,
  input logic                    Clr_n,
  sparc_window_regfile_if.slave  rf
);

  localparam int NPHYS  = int'(NUM_GLOBALS + REGS_PER_WIN * NWIN);
  localparam int PHYS_W = $clog2(NPHYS);

  logic [PHYS_W-1:0] rda_phys;
  logic [PHYS_W-1:0] rdb_phys;
  logic [PHYS_W-1:0] wr_phys;

  logic [CWP_W-1:0] cwp_reg, cwp_next;
  logic             wof_reg, wof_next;
  logic             wuf_reg, wuf_next;
  logic [CWP_W-1:0] cwp_dec;
  logic [CWP_W-1:0] cwp_inc;
  logic [CWP_W-1:0] cwp_ld_val;

  logic [DATA_W-1:0] regs_q [NPHYS];

  rf_addr_map #(.NWIN(NWIN), .CWP_W(CWP_W), .PHYS_W(PHYS_W)) u_map_a (
    .lreg (rf.RdA_Addr),
    .cwp  (cwp_reg),
    .phys (rda_phys)
  );

  rf_addr_map #(.NWIN(NWIN), .CWP_W(CWP_W), .PHYS_W(PHYS_W)) u_map_b (
    .lreg (rf.RdB_Addr),
    .cwp  (cwp_reg),
    .phys (rdb_phys)
  );

  // Write decode uses the pre-edge CWP, so a write alongside SAVE lands in the old window.
  rf_addr_map #(.NWIN(NWIN), .CWP_W(CWP_W), .PHYS_W(PHYS_W)) u_map_w (
    .lreg (rf.Wr_Addr),
    .cwp  (cwp_reg),
    .phys (wr_phys)
  );

  // Physical register 0 is hard-wired zero; every other entry is its own write-enabled register.
  assign regs_q[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NPHYS; gi++) begin : g_phys
      logic [DATA_W-1:0] data_reg;

      always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
          data_reg <= '0;
        end else if (rf.Wr_En && (wr_phys == PHYS_W'(gi))) begin
          data_reg <= rf.Wr_Data;
        end
      end

      assign regs_q[gi] = data_reg;
    end
  endgenerate

`ifdef RF_BYPASS_EN
  logic wr_live;
  assign wr_live  = rf.Wr_En && (wr_phys != '0);
  assign rf.PortA = (wr_live && (wr_phys == rda_phys)) ? rf.Wr_Data : regs_q[rda_phys];
  assign rf.PortB = (wr_live && (wr_phys == rdb_phys)) ? rf.Wr_Data : regs_q[rdb_phys];
`else
  assign rf.PortA = regs_q[rda_phys];
  assign rf.PortB = regs_q[rdb_phys];
`endif

  // Modulo-NWIN neighbours without a divider; valid for non-power-of-two NWIN.
  assign cwp_dec = (cwp_reg == '0) ? CWP_W'(NWIN - 1) : cwp_reg - CWP_W'(1);
  assign cwp_inc = (int'(cwp_reg) == NWIN - 1) ? '0 : cwp_reg + CWP_W'(1);

  // Cwp_In < 2**CWP_W < 2*NWIN, so one conditional subtract is a full mod-NWIN reduction.
  assign cwp_ld_val = (int'(rf.Cwp_In) >= NWIN) ? rf.Cwp_In - CWP_W'(NWIN) : rf.Cwp_In;

  always_comb begin
    cwp_next = cwp_reg;
    wof_next = 1'b0;
    wuf_next = 1'b0;
    if (rf.Cwp_Ld) begin
      cwp_next = cwp_ld_val;
    end else if (rf.Save && rf.Restore) begin
      cwp_next = cwp_reg;
    end else if (rf.Save) begin
      if (rf.WIM[cwp_dec]) begin
        wof_next = 1'b1;
      end else begin
        cwp_next = cwp_dec;
      end
    end else if (rf.Restore) begin
      if (rf.WIM[cwp_inc]) begin
        wuf_next = 1'b1;
      end else begin
        cwp_next = cwp_inc;
      end
    end
  end

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      cwp_reg <= '0;
      wof_reg <= 1'b0;
      wuf_reg <= 1'b0;
    end else begin
      cwp_reg <= cwp_next;
      wof_reg <= wof_next;
      wuf_reg <= wuf_next;
    end
  end

  assign rf.Cwp      = cwp_reg;
  assign rf.Wof_Trap = wof_reg;
  assign rf.Wuf_Trap = wuf_reg;

endmodule

// File: tb/tb_sparc_window_regfile.sv
// Self-checking bench for sparc_window_regfile (NWIN=4): directed scenarios, then random traffic vs. an array model.
module tb_sparc_window_regfile;

  localparam int NW = 4;
  localparam int NP = 8 + 16 * NW;

  logic Clk = 1'b0;
  logic Clr_n;

  always #5 Clk = ~Clk;

  sparc_window_regfile_if #(.DATA_W(32), .NWIN(NW)) rf_if ();

  sparc_window_regfile #(.DATA_W(32), .NWIN(NW)) dut (
    .Clk   (Clk),
    .Clr_n (Clr_n),
    .rf    (rf_if)
  );

  int checks = 0;
  int errors = 0;
  int n_step = 0;

  logic [31:0] m_regs [NP];
  int          m_cwp;

  function automatic int ref_phys(input int r, input int w);
    if (r < 8) return r;
    if (r < 24) return 8 + 16 * w + (r - 8);
    return 8 + 16 * ((w + 1) % NW) + (r - 24);
  endfunction

  function automatic logic [31:0] ref_read(input int r, input int wa, input logic we,
                                           input logic [31:0] wd);
    int p;
    p = ref_phys(r, m_cwp);
`ifdef RF_BYPASS_EN
    if (we && wa != 0 && ref_phys(wa, m_cwp) == p) return wd;
`endif
    return m_regs[p];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) m_regs[i] = '0;
    m_cwp = 0;
  endtask

  task automatic idle();
    rf_if.RdA_Addr = '0;
    rf_if.RdB_Addr = '0;
    rf_if.Wr_Addr  = '0;
    rf_if.Wr_Data  = '0;
    rf_if.Wr_En    = 1'b0;
    rf_if.Save     = 1'b0;
    rf_if.Restore  = 1'b0;
    rf_if.Cwp_Ld   = 1'b0;
    rf_if.Cwp_In   = '0;
    rf_if.WIM      = '0;
  endtask

  task automatic sync();
    idle();
    @(posedge Clk);
    #1;
  endtask

  task automatic peek(input logic [4:0] ra, input logic [4:0] rb);
    idle();
    rf_if.RdA_Addr = ra;
    rf_if.RdB_Addr = rb;
    #1;
  endtask

  // One clock: check reads before the edge, advance the model, check CWP/traps after the edge.
  task automatic step(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] wa,
                      input logic [31:0] wd, input logic we, input logic sv, input logic rs,
                      input logic ld, input logic [1:0] cin, input logic [3:0] wim);
    logic [31:0] exp_a, exp_b;
    logic        e_wof, e_wuf;
    int          nw;
    rf_if.RdA_Addr = ra;
    rf_if.RdB_Addr = rb;
    rf_if.Wr_Addr  = wa;
    rf_if.Wr_Data  = wd;
    rf_if.Wr_En    = we;
    rf_if.Save     = sv;
    rf_if.Restore  = rs;
    rf_if.Cwp_Ld   = ld;
    rf_if.Cwp_In   = cin;
    rf_if.WIM      = wim;
    #2;
    exp_a = ref_read(int'(ra), int'(wa), we, wd);
    exp_b = ref_read(int'(rb), int'(wa), we, wd);
    check("port_a", rf_if.PortA, exp_a);
    check("port_b", rf_if.PortB, exp_b);

    if (we && wa != 0) m_regs[ref_phys(int'(wa), m_cwp)] = wd;
    e_wof = 1'b0;
    e_wuf = 1'b0;
    if (ld) begin
      m_cwp = int'(cin) % NW;
    end else if (sv && rs) begin
      m_cwp = m_cwp;
    end else if (sv) begin
      nw = (m_cwp + NW - 1) % NW;
      if (wim[nw]) e_wof = 1'b1;
      else m_cwp = nw;
    end else if (rs) begin
      nw = (m_cwp + 1) % NW;
      if (wim[nw]) e_wuf = 1'b1;
      else m_cwp = nw;
    end

    @(posedge Clk);
    #1;
    check("cwp", 32'(rf_if.Cwp), 32'(m_cwp));
    check("wof_trap", 32'(rf_if.Wof_Trap), 32'(e_wof));
    check("wuf_trap", 32'(rf_if.Wuf_Trap), 32'(e_wuf));
    n_step++;
    $display("step %0d: ra=%0d rb=%0d we=%0b wa=%0d wd=%h sv=%0b rs=%0b ld=%0b cin=%0d wim=%b -> cwp=%0d wof=%0b wuf=%0b",
             n_step, ra, rb, we, wa, wd, sv, rs, ld, cin, wim, rf_if.Cwp, rf_if.Wof_Trap, rf_if.Wuf_Trap);
  endtask

  initial begin
    logic [31:0] bypass_exp;
    idle();
    Clr_n = 1'b1;
    #2;
    Clr_n = 1'b0;
    model_reset();
    #10;
    Clr_n = 1'b1;
    #1;
    check("rst_cwp", 32'(rf_if.Cwp), 32'd0);
    check("rst_wof", 32'(rf_if.Wof_Trap), 32'd0);
    check("rst_wuf", 32'(rf_if.Wuf_Trap), 32'd0);
    peek(5'd5, 5'd20);
    check("rst_r5", rf_if.PortA, 32'd0);
    check("rst_r20", rf_if.PortB, 32'd0);
    sync();

    // Populate state, then assert reset mid-cycle with a SAVE and a write in flight.
    step(5'd0, 5'd0, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 4'd0);
    step(5'd0, 5'd0, 5'd20, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    peek(5'd5, 5'd20);
    check("pre_rst_r5", rf_if.PortA, 32'hDEADBEEF);
    check("pre_rst_r20", rf_if.PortB, 32'hCAFEF00D);
    sync();
    rf_if.RdA_Addr = 5'd5;
    rf_if.RdB_Addr = 5'd20;
    rf_if.Save     = 1'b1;
    rf_if.Wr_En    = 1'b1;
    rf_if.Wr_Addr  = 5'd6;
    rf_if.Wr_Data  = 32'h11111111;
    #2;
    Clr_n = 1'b0;
    model_reset();
    #1;
    check("midrst_cwp", 32'(rf_if.Cwp), 32'd0);
    check("midrst_r5", rf_if.PortA, 32'd0);
    check("midrst_r20", rf_if.PortB, 32'd0);
    @(posedge Clk);
    #3;
    Clr_n = 1'b1;
    idle();
    @(posedge Clk);
    #1;
    check("postrst_cwp", 32'(rf_if.Cwp), 32'd0);
    peek(5'd6, 5'd5);
    check("postrst_r6_lost", rf_if.PortA, 32'd0);
    check("postrst_r5", rf_if.PortB, 32'd0);
    sync();

    // Window aliasing: outs of window 1 become ins of window 0.
    step(5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'd0);
    step(5'd0, 5'd0, 5'd8, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    step(5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
    check("alias_cwp", 32'(rf_if.Cwp), 32'd0);
    peek(5'd24, 5'd16);
    check("alias_r24", rf_if.PortA, 32'hA5A5A5A5);
    check("alias_r16", rf_if.PortB, 32'd0);
    sync();

    // Overflow at the wrap, single-cycle pulse, then an allowed wrap to NWIN-1.
    step(5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1000);
    check("wof_pulse", 32'(rf_if.Wof_Trap), 32'd1);
    check("wof_cwp_hold", 32'(rf_if.Cwp), 32'd0);
    step(5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b1000);
    check("wof_one_cycle", 32'(rf_if.Wof_Trap), 32'd0);
    step(5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000);
    check("save_wrap", 32'(rf_if.Cwp), 32'd3);

    // Underflow at the wrap, then Cwp_Ld beats Save.
    step(5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0001);
    check("wuf_pulse", 32'(rf_if.Wuf_Trap), 32'd1);
    check("wuf_cwp_hold", 32'(rf_if.Cwp), 32'd3);
    step(5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 4'b1111);
    check("ld_prio_cwp", 32'(rf_if.Cwp), 32'd2);
    check("ld_prio_notrap", 32'(rf_if.Wof_Trap), 32'd0);

    // r0 discards writes; globals are shared by every window.
    step(5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    peek(5'd0, 5'd0);
    check("r0_zero", rf_if.PortA, 32'd0);
    sync();
    step(5'd0, 5'd0, 5'd7, 32'h00001234, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    for (int w = 0; w < NW; w++) begin
      step(5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'(w), 4'd0);
      peek(5'd7, 5'd7);
      check("global_r7", rf_if.PortA, 32'h00001234);
      sync();
    end

    // Same-cycle read of a register being written.
    step(5'd0, 5'd0, 5'd9, 32'h00000055, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    idle();
    rf_if.RdA_Addr = 5'd9;
    rf_if.Wr_Addr  = 5'd9;
    rf_if.Wr_Data  = 32'h00000077;
    rf_if.Wr_En    = 1'b1;
    #1;
`ifdef RF_BYPASS_EN
    bypass_exp = 32'h00000077;
`else
    bypass_exp = 32'h00000055;
`endif
    check("bypass_r9", rf_if.PortA, bypass_exp);
    step(5'd9, 5'd9, 5'd9, 32'h00000077, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    peek(5'd9, 5'd9);
    check("after_write_r9", rf_if.PortA, 32'h00000077);
    sync();

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      logic [4:0]  ra, rb, wa;
      logic [31:0] wd;
      logic        we, sv, rs, ld;
      logic [3:0]  wim;
      int          op;
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      we  = 1'($urandom_range(0, 1));
      ra  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      rb  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      op  = $urandom_range(0, 9);
      sv  = (op <= 2) || (op == 6);
      rs  = (op >= 3 && op <= 5) || (op == 6);
      ld  = (op == 7);
      wim = 4'($urandom) & 4'($urandom);
      step(ra, rb, wa, wd, we, sv, rs, ld, 2'($urandom_range(0, 3)), wim);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sparc_window_regfile.md
Name: sparc_window_regfile

Overview:
- Parametrised SPARC windowed integer register file; next generation of the fixed-size window file in the datapath.
- Owns the Current Window Pointer (CWP) and executes SAVE and RESTORE internally.
- Checks the target window against WIM and raises window overflow/underflow trap pulses.
- Feeds ALU MuxA/MuxB through PortA/PortB and takes ALU results on the write port.

Parameters:
DATA_W, 32, register width in bits
NWIN, 8, number of windows; legal range 2..32
CWP_W, $clog2(NWIN), width of the CWP field

Ports:
Clk  input  1  system clock; all state updates on the rising edge
Clr_n  input  1  asynchronous, active-low reset
RdA_Addr  input  5  logical register for port A (IR[18:14] or IR[29:25])
RdB_Addr  input  5  logical register for port B (IR[4:0])
PortA  output  DATA_W  read data for port A
PortB  output  DATA_W  read data for port B
Wr_Addr  input  5  logical destination register
Wr_Data  input  DATA_W  write data
Wr_En  input  1  write enable
Save  input  1  SAVE request: decrement CWP
Restore  input  1  RESTORE request: increment CWP
Cwp_Ld  input  1  load CWP directly (WRPSR, trap entry)
Cwp_In  input  CWP_W  value loaded by Cwp_Ld
WIM  input  NWIN  window invalid mask
Cwp  output  CWP_W  current window pointer
Wof_Trap  output  1  window overflow, one-cycle pulse
Wuf_Trap  output  1  window underflow, one-cycle pulse

Behaviour:
- Storage: 8 + 16*NWIN physical registers.
- Globals r0..r7 map to physical 0..7. r0 always reads 0; writes to r0 are discarded.
- Window w block at base 8+16w: r8..r15 (outs) map to base+0..7; r16..r23 (locals) map to base+8..15.
- r24..r31 (ins) map to the outs of window (w+1) mod NWIN, i.e. 8+16*((w+1) mod NWIN)+(r-24).
- Reads are combinational from the current Cwp; no read latency.
- Writes are synchronous. Address decode uses the Cwp value held before the edge, so a write in the same cycle as a SAVE lands in the old window. The controller issues the SAVE rd write one cycle later.
- CWP update priority per edge, highest first:
  1. Cwp_Ld: Cwp <= Cwp_In. Out-of-range values (>= NWIN) are reduced mod NWIN. No trap check.
  2. Save and Restore both high: no CWP change, no trap (illegal, ignored).
  3. Save: nw = (Cwp-1) mod NWIN; Cwp 0 wraps to NWIN-1. If WIM[nw], Cwp holds and Wof_Trap=1 for the next cycle; else Cwp <= nw.
  4. Restore: nw = (Cwp+1) mod NWIN; Cwp NWIN-1 wraps to 0. If WIM[nw], Cwp holds and Wuf_Trap=1; else Cwp <= nw.
- Trap outputs are registered and high exactly one cycle per offending request. Back-to-back blocked requests give back-to-back pulses.
- Reset (Clr_n low, asynchronous, any time including mid-SAVE):
  - Cwp=0, Wof_Trap=0, Wuf_Trap=0, all physical registers=0.
  - Any write or CWP update in flight on the reset edge is lost.
- Arithmetic: CWP math is modulo NWIN, correct for non-power-of-two NWIN.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined: when Wr_En=1 and a read port's physical index equals the write's physical index (nonzero), that port returns Wr_Data in the same cycle. This includes an ins/outs alias across adjacent windows.
- Undefined: the read port returns the pre-write stored value; the new value is visible the cycle after the edge.

Decomposition:
- Package sparc_rf_pkg holds:
  - constants NUM_GLOBALS=8, REGS_PER_WIN=16, OUTS_BASE=8, LOCALS_BASE=16, INS_BASE=24;
  - the physical-index function phys_idx(logical, cwp, nwin).
- Sub-module rf_addr_map: logical register + CWP to physical index, purely combinational. Instantiated three times (RdA, RdB, Wr).

Test Plan (NWIN=4):
- Reset: Clr_n low mid-cycle -> Cwp=0, traps 0; read r5 and r20 -> 0.
- Window aliasing: at Cwp=1 write r8=32'hA5A5A5A5; Save with WIM=0 -> Cwp=0; read r24 -> 32'hA5A5A5A5. Read r16 -> 0, since window 0's locals are distinct.
- Wrap and overflow: Cwp=0, WIM=4'b1000, Save -> Cwp stays 0, Wof_Trap high for exactly 1 cycle. WIM=0, Save -> Cwp=3.
- Underflow and priority: Cwp=3, WIM=4'b0001, Restore -> Wuf_Trap pulse, Cwp=3. Cwp_Ld=1 with Cwp_In=2 and Save=1 -> Cwp=2, no trap.
- r0 and globals: write r0=32'hFFFFFFFF -> reads 0. Write r7=32'h1234 at Cwp=2 -> r7 reads 32'h1234 at every Cwp.
- Bypass: write r9=32'h77 while RdA_Addr=9 -> PortA=32'h77 the same cycle with RF_BYPASS_EN defined; old value without it.
